// File: rtl/conv1_pkg.sv
// conv1_pkg
//   Shared constants for the conv1 window generator: default image geometry,
//   kernel size, window width and the byte slots inside a packed 3x3 window.
//   Byte k of a window sits at bits [8k+7:8k], with k = 3*dy + dx.
package conv1_pkg;

    localparam int unsigned IMG_H     = 32;
    localparam int unsigned IMG_W     = 32;
    localparam int unsigned IMG_CH    = 3;
    localparam int unsigned K         = 3;
    localparam int unsigned WIN_BYTES = K * K;
    localparam int unsigned WIN_BITS  = 8 * WIN_BYTES;

    // Byte index of each window tap (top/mid/bottom row, left/centre/right column)
    localparam int unsigned WB_TL = 0;
    localparam int unsigned WB_TC = 1;
    localparam int unsigned WB_TR = 2;
    localparam int unsigned WB_ML = 3;
    localparam int unsigned WB_MC = 4;
    localparam int unsigned WB_MR = 5;
    localparam int unsigned WB_BL = 6;
    localparam int unsigned WB_BC = 7;
    localparam int unsigned WB_BR = 8;

    // Bit offset of window tap (dy, dx)
    function automatic int unsigned win_lsb(input int unsigned dy, input int unsigned dx);
        return 8 * (K * dy + dx);
    endfunction

endpackage

// File: rtl/conv1_window_gen_line_buffer.sv
// line_buffer
//   One image row of byte storage. Single address per cycle: the read port is
//   combinational and returns the old contents, the write lands on the clock
//   edge (read-before-write). Contents are not reset.
// Ports:
//   clk    clock
//   we     write enable
//   addr   read/write address (column)
//   wdata  byte written at addr on the rising edge when we=1
//   rdata  current contents at addr
module line_buffer #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv1_window_gen.sv
// conv1_window_gen
//   Streaming 3x3 window generator. Takes a planar raster byte stream
//   (plane 0 rows, then plane 1, ...) and emits one registered 3x3 window per
//   valid-convolution position, tagged with plane, row and column.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous restart of counters and outputs
//   s_valid/s_ready   input byte handshake, s_data = pixel
//   w_valid/w_ready   window handshake
//   w_data            72-bit window, byte 3*dy+dx, byte 8 = newest pixel
//   w_row/w_col/w_ch  top-left position and plane of the window
//   w_last            last window of the frame
//   frame_done        pulse after the frame's last byte is accepted
module conv1_window_gen
    import conv1_pkg::*;
#(
    parameter int H  = IMG_H,
    parameter int W  = IMG_W,
    parameter int CH = IMG_CH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WIN_BITS-1:0]   w_data,
    output logic [$clog2(H)-1:0]  w_row,
    output logic [$clog2(W)-1:0]  w_col,
    output logic [$clog2(CH)-1:0] w_ch,
    output logic                  w_last,
    output logic                  frame_done
);

    localparam int RB = $clog2(H);
    localparam int CB = $clog2(W);
    localparam int PB = $clog2(CH);

    localparam logic [CB-1:0] COL_MAX   = CB'(W - 1);
    localparam logic [RB-1:0] ROW_MAX   = RB'(H - 1);
    localparam logic [PB-1:0] CH_MAX    = PB'(CH - 1);
    localparam logic [CB-1:0] COL_FIRST = CB'(K - 1);
    localparam logic [RB-1:0] ROW_FIRST = RB'(K - 1);

    logic [CB-1:0]       col;
    logic [RB-1:0]       row;
    logic [PB-1:0]       ch;
    logic                accept;
    logic                win_ok;
    logic                last_pos;
    logic                col_wrap;
    logic                row_wrap;
    logic [7:0]          rd1;
    logic [7:0]          rd2;
    logic [WIN_BITS-1:0] shift_q;
    logic [WIN_BITS-1:0] shift_d;

    // Only a held, unconsumed window blocks the input.
    assign s_ready  = !w_valid || w_ready;
    assign accept   = s_valid && s_ready;
    assign col_wrap = (col == COL_MAX);
    assign row_wrap = (row == ROW_MAX);
    assign last_pos = col_wrap && row_wrap && (ch == CH_MAX);
    // Window emission is gated purely by position, so stale buffer contents
    // from a previous plane or an aborted frame never reach w_data.
    assign win_ok   = (row >= ROW_FIRST) && (col >= COL_FIRST);

    // lb1 holds row-1, lb2 holds row-2; lb2 is refilled from lb1's old value.
    line_buffer #(.DEPTH(W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (s_data),
        .rdata (rd1)
    );

    line_buffer #(.DEPTH(W)) u_lb2 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (rd1),
        .rdata (rd2)
    );

    // Shift the 3x3 window left one column and insert the new column.
    always_comb begin
        shift_d = shift_q;
        for (int unsigned dy = 0; dy < K; dy++) begin
            for (int unsigned dx = 0; dx < K - 1; dx++) begin
                shift_d[win_lsb(dy, dx) +: 8] = shift_q[win_lsb(dy, dx + 1) +: 8];
            end
        end
        shift_d[8*WB_TR +: 8] = rd2;
        shift_d[8*WB_MR +: 8] = rd1;
        shift_d[8*WB_BR +: 8] = s_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            w_row      <= '0;
            w_col      <= '0;
            w_ch       <= '0;
            w_last     <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            w_row      <= '0;
            w_col      <= '0;
            w_ch       <= '0;
            w_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_pos;
            if (accept) begin
                col <= col_wrap ? '0 : col + 1'b1;
                if (col_wrap) begin
                    row <= row_wrap ? '0 : row + 1'b1;
                    if (row_wrap) begin
                        ch <= (ch == CH_MAX) ? '0 : ch + 1'b1;
                    end
                end
                // Reload or drop the output register in the same edge.
                w_valid <= win_ok;
                if (win_ok) begin
                    w_data <= shift_d;
                    w_row  <= row - ROW_FIRST;
                    w_col  <= col - COL_FIRST;
                    w_ch   <= ch;
                    w_last <= last_pos;
                end
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end

endmodule
